// File: rtl/seeg_pkg.sv
// Shared types and constants for the sEEG record path.
// Batcher FSM encoding, default batch size and sample width.
package seeg_pkg;

    localparam int unsigned SEEG_SAMPLE_W      = 32;
    localparam logic [15:0] SEEG_DEFAULT_BATCH = 16'd4;

    typedef enum logic [1:0] {
        BATCH_IDLE = 2'd0,
        BATCH_RUN  = 2'd1,
        BATCH_PAD  = 2'd2
    } batcher_state_t;

    // A batch size of zero behaves as one word per packet.
    function automatic logic [15:0] clamp_batch(input logic [15:0] b);
        return (b == 16'd0) ? 16'd1 : b;
    endfunction

endpackage

// File: rtl/seeg_sync_fifo.sv
// First-word-fall-through synchronous FIFO with registered head, valid, full and level.
// The head register is preloaded with the next entry so the read port has no combinational path.
module seeg_sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n, level_n;
    logic [WIDTH-1:0] head_n;
    logic             push, pop;

    // Pointer arithmetic; the extra MSB separates full from empty.
    always_comb begin
        push     = wr_en && !full;
        pop      = rd_en && rd_valid;
        wr_ptr_n = wr_ptr + PW'(push);
        rd_ptr_n = rd_ptr + PW'(pop);
        level_n  = wr_ptr_n - rd_ptr_n;
    end

    // Next head entry; a push into an empty (or just-drained) FIFO lands directly here.
    always_comb begin
        head_n = '0;
        if (level_n != '0) begin
            if (push && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) begin
                head_n = wr_data;
            end else begin
                head_n = mem[rd_ptr_n[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            full     <= 1'b0;
            level    <= '0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            rd_data  <= head_n;
            rd_valid <= (level_n != '0);
            full     <= (level_n == PW'(DEPTH));
            level    <= level_n;
        end
    end

endmodule

// File: rtl/seeg_axis_batcher.sv
// Packs recorded samples into fixed-size AXI4-Stream packets, padding a partial batch on stop.
// The last flag is fixed at write time so buffered words never need rewriting.
module seeg_axis_batcher
    import seeg_pkg::*;
#(
    parameter int unsigned      DATA_W     = SEEG_SAMPLE_W,
    parameter int unsigned      FIFO_DEPTH = 64,
    parameter logic [DATA_W-1:0] PAD_WORD  = '0
) (
    input  logic                          M_AXIS_ACLK,
    input  logic                          M_AXIS_ARESETN,
    input  logic                          record_en,
    input  logic [15:0]                   batch_size,
    input  logic                          s_valid,
    input  logic [DATA_W-1:0]             s_data,
    output logic [DATA_W-1:0]             M_AXIS_tdata,
    output logic                          M_AXIS_tvalid,
    output logic                          M_AXIS_tlast,
    input  logic                          M_AXIS_tready,
    output logic [15:0]                   ovf_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [1:0] ST_IDLE = BATCH_IDLE;
    localparam logic [1:0] ST_RUN  = BATCH_RUN;
    localparam logic [1:0] ST_PAD  = BATCH_PAD;

    logic [1:0]       state, state_n;
    logic [15:0]      bs, bs_n, word_cnt, word_cnt_n, ovf_n;
    logic             busy_n, at_end, wr_en, pop, fifo_full;
    logic [DATA_W:0]  wr_entry, head;
    logic [LVL_W-1:0] level_n;

    assign at_end = (word_cnt == bs - 16'd1);

    // Next-state, batch counter and overflow counter.
    always_comb begin
        state_n    = state;
        bs_n       = bs;
        word_cnt_n = word_cnt;
        ovf_n      = ovf_count;
        wr_en      = 1'b0;
        wr_entry   = {at_end, s_data};
        case (state)
            ST_IDLE: begin
                if (record_en) begin
                    bs_n       = clamp_batch(batch_size);
                    word_cnt_n = '0;
                    ovf_n      = '0;
                    state_n    = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!record_en) begin
                    state_n = (word_cnt == 16'd0) ? ST_IDLE : ST_PAD;
                end else if (s_valid) begin
                    if (!fifo_full) begin
                        wr_en      = 1'b1;
                        word_cnt_n = at_end ? 16'd0 : word_cnt + 16'd1;
                    end else if (ovf_count != 16'hFFFF) begin
                        ovf_n = ovf_count + 16'd1;
                    end
                end
            end
            ST_PAD: begin
                if (!fifo_full) begin
                    wr_en      = 1'b1;
                    wr_entry   = {at_end, PAD_WORD};
                    word_cnt_n = at_end ? 16'd0 : word_cnt + 16'd1;
                    if (at_end) begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // wr_en is only raised when the FIFO has room, so it equals the accepted push.
        pop     = M_AXIS_tvalid && M_AXIS_tready;
        level_n = fifo_level + LVL_W'(wr_en) - LVL_W'(pop);
        busy_n  = (state_n != ST_IDLE) || (level_n != '0);
    end

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            state     <= ST_IDLE;
            bs        <= 16'd1;
            word_cnt  <= '0;
            ovf_count <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            bs        <= bs_n;
            word_cnt  <= word_cnt_n;
            ovf_count <= ovf_n;
            busy      <= busy_n;
        end
    end

    seeg_sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (M_AXIS_ACLK),
        .rst_n    (M_AXIS_ARESETN),
        .wr_en    (wr_en),
        .wr_data  (wr_entry),
        .rd_en    (M_AXIS_tready),
        .rd_data  (head),
        .rd_valid (M_AXIS_tvalid),
        .full     (fifo_full),
        .level    (fifo_level)
    );

    assign M_AXIS_tdata = head[DATA_W-1:0];
    assign M_AXIS_tlast = head[DATA_W];

endmodule

// File: tb/tb_seeg_axis_batcher.sv
// Self-checking bench for seeg_axis_batcher: queue-based reference model compared every cycle,
// plus literal checks on the delivered packet streams.
module tb_seeg_axis_batcher;
    import seeg_pkg::*;

    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          record_en  = 1'b0;
    logic [15:0]   batch_size = 16'd0;
    logic          s_valid    = 1'b0;
    logic [DW-1:0] s_data     = '0;
    logic          tready     = 1'b0;
    logic [DW-1:0] tdata;
    logic          tvalid, tlast, busy;
    logic [15:0]   ovf_count;
    logic [LW-1:0] fifo_level;

    always #5 clk = ~clk;

    seeg_axis_batcher #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .PAD_WORD   (32'h0000_0000)
    ) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .record_en      (record_en),
        .batch_size     (batch_size),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .M_AXIS_tdata   (tdata),
        .M_AXIS_tvalid  (tvalid),
        .M_AXIS_tlast   (tlast),
        .M_AXIS_tready  (tready),
        .ovf_count      (ovf_count),
        .fifo_level     (fifo_level),
        .busy           (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a session writes words numbered 0,1,2..; word k closes a packet when k%bs==bs-1.
    logic [DW:0] mq[$];
    bit          rec_on  = 1'b0;
    bit          pad_on  = 1'b0;
    int          m_bs    = 1;
    int          m_wr    = 0;
    logic [15:0] m_ovf   = '0;
    bit          do_pop, is_full, last_w;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            rec_on = 1'b0;
            pad_on = 1'b0;
            m_bs   = 1;
            m_wr   = 0;
            m_ovf  = '0;
        end else begin
            do_pop  = (mq.size() > 0) && tready;
            is_full = (mq.size() == DEPTH);
            if (!rec_on && !pad_on) begin
                if (record_en) begin
                    rec_on = 1'b1;
                    m_bs   = (batch_size == 16'd0) ? 1 : int'(batch_size);
                    m_wr   = 0;
                    m_ovf  = '0;
                end
            end else if (rec_on) begin
                if (!record_en) begin
                    rec_on = 1'b0;
                    pad_on = (m_wr % m_bs) != 0;
                end else if (s_valid) begin
                    if (!is_full) begin
                        mq.push_back({(m_wr % m_bs) == m_bs - 1, s_data});
                        m_wr++;
                    end else if (m_ovf != 16'hFFFF) begin
                        m_ovf = m_ovf + 16'd1;
                    end
                end
            end else if (!is_full) begin
                last_w = (m_wr % m_bs) == m_bs - 1;
                mq.push_back({last_w, 32'h0000_0000});
                m_wr++;
                if (last_w) pad_on = 1'b0;
            end
            if (do_pop) void'(mq.pop_front());
        end
    end

    // Per-cycle compare against the model, AXIS hold rule, and capture of delivered words.
    logic [DW:0] log_q[$];
    bit          hold_prev = 1'b0;
    logic [DW:0] prev_word = '0;
    logic [DW:0] exp_word;
    bit          exp_valid;

    always @(negedge clk) begin
        exp_valid = mq.size() > 0;
        exp_word  = exp_valid ? mq[0] : '0;
        check("tvalid", 64'(tvalid), 64'(exp_valid));
        check("tdata", 64'(tdata), 64'(exp_word[DW-1:0]));
        check("tlast", 64'(tlast), 64'(exp_word[DW]));
        check("fifo_level", 64'(fifo_level), 64'(mq.size()));
        check("ovf_count", 64'(ovf_count), 64'(m_ovf));
        check("busy", 64'(busy), 64'(rec_on || pad_on || mq.size() > 0));
        if (rst_n && hold_prev) begin
            check("axis_hold", 64'({tvalid, tlast, tdata}), 64'({1'b1, prev_word}));
        end
        hold_prev = rst_n && tvalid && !tready;
        prev_word = {tlast, tdata};
        if (rst_n && tvalid && tready) log_q.push_back({tlast, tdata});
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 1000) begin
            cyc(1);
            t++;
        end
        check("idle_timeout", 64'(busy), 64'(0));
        cyc(2);
    endtask

    task automatic send(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(base + i);
            cyc(1);
        end
        s_valid = 1'b0;
    endtask

    task automatic start_rec();
        log_q.delete();
        record_en = 1'b1;
        cyc(1);
    endtask

    task automatic stop_rec();
        record_en = 1'b0;
        cyc(1);
    endtask

    task automatic check_log_len(input string name, input int n);
        check(name, 64'(log_q.size()), 64'(n));
    endtask

    initial begin
        #12;
        check("rst_tvalid", 64'(tvalid), 64'(0));
        check("rst_tdata", 64'(tdata), 64'(0));
        check("rst_tlast", 64'(tlast), 64'(0));
        check("rst_level", 64'(fifo_level), 64'(0));
        check("rst_ovf", 64'(ovf_count), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        cyc(1);
        rst_n = 1'b1;
        cyc(2);

        // 1: two packets of four; each word visible one cycle after its strobe
        batch_size = SEEG_DEFAULT_BATCH;
        tready     = 1'b1;
        start_rec();
        for (int i = 1; i <= 8; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i);
            cyc(1);
            check("t1_latency_valid", 64'(tvalid), 64'(1));
            check("t1_latency_data", 64'(tdata), 64'(i));
        end
        s_valid = 1'b0;
        stop_rec();
        wait_idle();
        check_log_len("t1_len", 8);
        for (int k = 0; k < 8; k++) begin
            check("t1_data", 64'(log_q[k][DW-1:0]), 64'(k + 1));
            check("t1_last", 64'(log_q[k][DW]), 64'((k == 3) || (k == 7)));
        end

        // 2: partial batch padded with zeros on stop
        start_rec();
        send(6, 1);
        stop_rec();
        wait_idle();
        check_log_len("t2_len", 8);
        for (int k = 0; k < 8; k++) begin
            check("t2_data", 64'(log_q[k][DW-1:0]), 64'((k < 6) ? k + 1 : 0));
            check("t2_last", 64'(log_q[k][DW]), 64'((k == 3) || (k == 7)));
        end

        // 3: overflow with downstream stalled
        tready = 1'b0;
        start_rec();
        send(70, 1);
        cyc(1);
        check("t3_level", 64'(fifo_level), 64'(64));
        check("t3_ovf", 64'(ovf_count), 64'(6));
        stop_rec();
        cyc(1);
        tready = 1'b1;
        wait_idle();
        check_log_len("t3_len", 64);
        for (int k = 0; k < 64; k++) begin
            check("t3_data", 64'(log_q[k][DW-1:0]), 64'(k + 1));
            check("t3_last", 64'(log_q[k][DW]), 64'((k % 4) == 3));
        end
        check("t3_ovf_kept", 64'(ovf_count), 64'(6));

        // 4: random backpressure, no loss
        start_rec();
        for (int i = 0; i < 40; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(100 + i);
            tready  = 1'($urandom_range(0, 1));
            cyc(1);
        end
        s_valid = 1'b0;
        stop_rec();
        for (int i = 0; i < 20; i++) begin
            tready = 1'($urandom_range(0, 1));
            cyc(1);
        end
        tready = 1'b1;
        wait_idle();
        check_log_len("t4_len", 40);
        for (int k = 0; k < 40; k++) begin
            check("t4_data", 64'(log_q[k][DW-1:0]), 64'(100 + k));
            check("t4_last", 64'(log_q[k][DW]), 64'((k % 4) == 3));
        end

        // 5: batch_size 0 means one word per packet; mid-run change ignored
        batch_size = 16'd0;
        start_rec();
        send(3, 200);
        batch_size = 16'd2;
        send(3, 203);
        stop_rec();
        wait_idle();
        check_log_len("t5_len", 6);
        for (int k = 0; k < 6; k++) begin
            check("t5_data", 64'(log_q[k][DW-1:0]), 64'(200 + k));
            check("t5_last", 64'(log_q[k][DW]), 64'(1));
        end
        start_rec();
        send(4, 300);
        stop_rec();
        wait_idle();
        check_log_len("t5b_len", 4);
        for (int k = 0; k < 4; k++) begin
            check("t5b_last", 64'(log_q[k][DW]), 64'((k % 2) == 1));
        end

        // 6: reset mid-packet discards everything
        batch_size = 16'd4;
        tready     = 1'b0;
        start_rec();
        send(10, 1);
        cyc(1);
        check("t6_level_pre", 64'(fifo_level), 64'(10));
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tvalid", 64'(tvalid), 64'(0));
        check("t6_rst_level", 64'(fifo_level), 64'(0));
        check("t6_rst_ovf", 64'(ovf_count), 64'(0));
        record_en = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        tready = 1'b1;
        start_rec();
        send(4, 51);
        stop_rec();
        wait_idle();
        check_log_len("t6_len", 4);
        for (int k = 0; k < 4; k++) begin
            check("t6_data", 64'(log_q[k][DW-1:0]), 64'(51 + k));
            check("t6_last", 64'(log_q[k][DW]), 64'(k == 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
